key_debounce_edge: RTL and testbench
====================================

// Module: key_debounce_edge
// PURPOSE
//   Multi-channel push-button front end: synchronises N raw key inputs, debounces each
//   independently, and emits one-cycle rise (press), fall (release) and auto-repeat pulses.
//   Sits between board key pins and UI/control FSMs; generalises the single-key rise
//   detector with polarity, debounce, falling edges and hold-to-repeat.
// PARAMETERS
//   N_KEYS        4       number of independent key channels (>=1)
//   SYNC_STAGES   2       synchroniser flops per channel (>=2)
//   DB_CYCLES     270000  consecutive stable cycles needed to accept a change (>=1; 10 ms @ 27 MHz)
//   ACTIVE_LOW    1       1: raw key reads 0 when pressed; 0: reads 1 when pressed
//   REPEAT_DELAY  0       cycles from rise to first rpt pulse; 0 disables auto-repeat
//   REPEAT_PERIOD 2700000 cycles between subsequent rpt pulses (>=1)
// PORTS
//   clk    in   1        system clock, all logic on posedge
//   nrst   in   1        asynchronous active-low reset
//   in     in   N_KEYS   raw asynchronous key pins
//   level  out  N_KEYS   debounced state, 1 = pressed (polarity-normalised)
//   rise   out  N_KEYS   1-cycle pulse when level goes 0->1
//   fall   out  N_KEYS   1-cycle pulse when level goes 1->0
//   rpt    out  N_KEYS   1-cycle auto-repeat pulse while level held 1
// BEHAVIOUR
//   Reset (nrst=0, async): level, rise, fall, rpt = 0; all counters = 0; sync flops load the
//     "released" raw value (ACTIVE_LOW ? 1 : 0) so release of reset causes no spurious edge.
//   Per channel, fully independent; no cross-channel interaction or priority.
//   Sync: s = in[i] through SYNC_STAGES flops, then inverted if ACTIVE_LOW -> p (1 = pressed).
//   Debounce counter dbc (width $clog2(DB_CYCLES+1)):
//     - p == level: dbc <= 0.
//     - p != level and dbc < DB_CYCLES-1: dbc <= dbc+1.
//     - p != level and dbc == DB_CYCLES-1: level <= p, dbc <= 0, pulse rise or fall.
//     - any glitch back to p == level restarts the count from 0 (no partial credit).
//   Latency: raw change sampled at edge 1 -> level/rise/fall update at edge SYNC_STAGES+DB_CYCLES.
//   rise/fall registered, high exactly one cycle, never both in same cycle for a channel.
//   Per-channel state machine: RELEASED (level=0) -> PRESSED (level=1) on accepted press;
//     PRESSED -> RELEASED on accepted release. Repeat logic active only in PRESSED.
//   Auto-repeat (REPEAT_DELAY>0): repeat counter rc cleared in the rise cycle; rpt pulses at
//     rise_edge+REPEAT_DELAY, then every REPEAT_PERIOD cycles while PRESSED; rpt never coincides
//     with rise; rpt suppressed in the fall cycle; rc cleared on fall. rc saturates/wraps only
//     within its own width ($clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1)); no overflow into other state.
//   REPEAT_DELAY==0: rpt tied 0, repeat counters not synthesised.
//   Reset mid-operation: all channel state lost immediately; a key still pressed at reset release
//     is re-detected and yields a fresh rise after SYNC_STAGES+DB_CYCLES cycles.
// TESTING  (N_KEYS=2, SYNC_STAGES=2, DB_CYCLES=4, ACTIVE_LOW=1, REPEAT_DELAY=10, REPEAT_PERIOD=3)
//   1 Reset with in=2'b11, release, idle 20 cycles -> level=00, no rise/fall/rpt pulse at any time.
//   2 in[0] 1->0 held -> level[0] and rise[0]=1 at edge 6 after change, rise[0] low from edge 7.
//   3 in[0] toggles every 2 cycles for 20 cycles, then held 0 -> no pulses during bounce; exactly
//     one rise[0] 6 cycles after the final stable low.
//   4 Hold ch0 pressed 30 cycles after rise at edge E -> rpt[0] at E+10, E+13, E+16...; release ->
//     fall[0] 6 cycles later, no rpt in or after fall cycle.
//   5 in 11->00 same cycle -> rise=2'b11 same cycle; release only ch1 -> fall=2'b10, ch0 unaffected.
//   6 Ch0 held pressed, nrst pulsed low mid-repeat -> outputs 0 asynchronously; after nrst=1 with
//     key still low -> rise[0] at edge 6, repeat sequence restarts from new rise.

Source files
------------

// File: rtl/key_debounce_edge.sv
// Multi-channel key front end: per-key synchroniser, debounce filter, and one-cycle
// press/release/auto-repeat pulses. Each channel is an independent lane instance.

module key_debounce_lane #(
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = 270000,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 2700000
) (
  input  logic clk,
  input  logic nrst,
  input  logic key,
  output logic level,
  output logic rise,
  output logic fall,
  output logic rpt
);
  localparam int                DBC_W   = $clog2(DB_CYCLES + 1);
  localparam logic              REL     = (ACTIVE_LOW != 0);
  localparam logic [DBC_W-1:0]  DB_LAST = DBC_W'(DB_CYCLES - 1);

  localparam logic [0:0] ST_RELEASED = 1'b0;
  localparam logic [0:0] ST_PRESSED  = 1'b1;

  logic [SYNC_STAGES-1:0] sync;
  logic                   p;
  logic [DBC_W-1:0]       dbc;
  logic [0:0]             state;
  logic                   accept;

  // Reset to the released pin value so reset release never looks like a press.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) sync <= {SYNC_STAGES{REL}};
    else       sync <= {sync[SYNC_STAGES-2:0], key};
  end

  assign p      = sync[SYNC_STAGES-1] ^ REL;
  assign level  = (state == ST_PRESSED);
  assign accept = (p != level) && (dbc == DB_LAST);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= ST_RELEASED;
      dbc   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (p == level) begin
        dbc <= '0;
      end else if (accept) begin
        dbc   <= '0;
        state <= p ? ST_PRESSED : ST_RELEASED;
        rise  <= p;
        fall  <= !p;
      end else begin
        dbc <= dbc + DBC_W'(1);
      end
    end
  end

  generate
    if (REPEAT_DELAY > 0) begin : g_rpt
      localparam int               RC_MAX   = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int               RC_W     = $clog2(RC_MAX + 1);
      localparam logic [RC_W-1:0]  DLY_LAST = RC_W'(REPEAT_DELAY - 1);
      localparam logic [RC_W-1:0]  PER_LAST = RC_W'(REPEAT_PERIOD - 1);

      logic [RC_W-1:0] rc;
      logic            armed;   // 0: waiting for first repeat, 1: periodic phase

      // rc is held at 0 while released and in any accept cycle, so the first
      // pulse lands exactly REPEAT_DELAY edges after rise and none in the fall cycle.
      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          rc    <= '0;
          armed <= 1'b0;
          rpt   <= 1'b0;
        end else begin
          rpt <= 1'b0;
          if (!level || accept) begin
            rc    <= '0;
            armed <= 1'b0;
          end else if (rc == (armed ? PER_LAST : DLY_LAST)) begin
            rc    <= '0;
            armed <= 1'b1;
            rpt   <= 1'b1;
          end else begin
            rc <= rc + RC_W'(1);
          end
        end
      end
    end else begin : g_no_rpt
      assign rpt = 1'b0;
    end
  endgenerate
endmodule

module key_debounce_edge #(
  parameter int N_KEYS        = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = 270000,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 2700000
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [N_KEYS-1:0] in,
  output logic [N_KEYS-1:0] level,
  output logic [N_KEYS-1:0] rise,
  output logic [N_KEYS-1:0] fall,
  output logic [N_KEYS-1:0] rpt
);
  for (genvar i = 0; i < N_KEYS; i++) begin : g_lane
    key_debounce_lane #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DB_CYCLES    (DB_CYCLES),
      .ACTIVE_LOW   (ACTIVE_LOW),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_lane (
      .clk  (clk),
      .nrst (nrst),
      .key  (in[i]),
      .level(level[i]),
      .rise (rise[i]),
      .fall (fall[i]),
      .rpt  (rpt[i])
    );
  end
endmodule

// File: tb/tb_key_debounce_edge.sv
// Scoreboard bench: expected pulse events are queued (sorted by cycle) as keys are driven,
// and every cycle the outputs are compared against the queue head or idle.

module tb_key_debounce_edge;
  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [1:0] in_r = 2'b11;
  logic [1:0] level, rise, fall, rpt;

  key_debounce_edge #(
    .N_KEYS(2), .SYNC_STAGES(2), .DB_CYCLES(4), .ACTIVE_LOW(1),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .clk(clk), .nrst(nrst), .in(in_r),
    .level(level), .rise(rise), .fall(fall), .rpt(rpt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         c;
    logic [1:0] r;
    logic [1:0] f;
    logic [1:0] p;
  } ev_t;

  ev_t        q[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_err = 0;
  logic       mon_en = 1'b0;
  logic [1:0] exp_lvl = 2'b00;
  string      tag = "init";

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string t, input logic [7:0] obs, input logic [7:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h (level,rise,fall,rpt)", t, cyc, obs, expv);
    end
  endtask

  // Insert/merge an event (kind 0 rise, 1 fall, 2 rpt) keeping the queue cycle-sorted.
  task automatic push_ev(input int c, input int ch, input int kind);
    ev_t e;
    int  i = 0;
    while (i < q.size() && q[i].c < c) i++;
    if (i < q.size() && q[i].c == c) e = q[i];
    else begin
      e.c = c; e.r = 2'b00; e.f = 2'b00; e.p = 2'b00;
    end
    case (kind)
      0:       e.r[ch] = 1'b1;
      1:       e.f[ch] = 1'b1;
      default: e.p[ch] = 1'b1;
    endcase
    if (i < q.size() && q[i].c == c) q[i] = e;
    else q.insert(i, e);
  endtask

  // Key driven low after edge k and high after edge r: rise k+6, fall r+6,
  // repeats at rise+10 then every 3, strictly before the fall edge.
  task automatic press_seq(input int ch, input int k, input int r);
    push_ev(k + 6, ch, 0);
    push_ev(r + 6, ch, 1);
    for (int c = k + 16; c < r + 6; c += 3) push_ev(c, ch, 2);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (mon_en) begin
      e.c = cyc; e.r = 2'b00; e.f = 2'b00; e.p = 2'b00;
      if (!nrst) begin
        q.delete();
        exp_lvl = 2'b00;
      end else if (q.size() > 0 && q[0].c == cyc) begin
        e = q.pop_front();
      end
      exp_lvl = (exp_lvl | e.r) & ~e.f;
      chk(tag, {level, rise, fall, rpt}, {exp_lvl, e.r, e.f, e.p});
    end
  end

  initial begin
    int k;
    tag = "reset";
    tick(1);
    mon_en = 1'b1;
    tick(2);
    nrst = 1'b1;

    tag = "idle";
    tick(20);

    tag = "press";
    k = cyc; in_r[0] = 1'b0; press_seq(0, k, k + 10);
    tick(10); in_r[0] = 1'b1;
    tick(15);

    tag = "bounce";
    k = cyc;
    for (int i = 0; i < 10; i++) begin
      in_r[0] = (i % 2 == 1);
      tick(2);
    end
    in_r[0] = 1'b0; press_seq(0, k + 20, k + 28);
    tick(8); in_r[0] = 1'b1;
    tick(15);

    tag = "repeat";
    k = cyc; in_r[0] = 1'b0; press_seq(0, k, k + 37);
    tick(37); in_r[0] = 1'b1;
    tick(15);

    tag = "dual";
    k = cyc; in_r = 2'b00; press_seq(0, k, k + 20); press_seq(1, k, k + 8);
    tick(8); in_r[1] = 1'b1;
    tick(12); in_r[0] = 1'b1;
    tick(15);

    tag = "rst_mid";
    k = cyc; in_r[0] = 1'b0; press_seq(0, k, k + 40);
    tick(22);
    chk("pre_rst", {level, rise, fall, rpt}, 8'b01_00_00_01);
    nrst = 1'b0;
    #1 chk("async_rst", {level, rise, fall, rpt}, 8'h00);
    tick(3);
    nrst = 1'b1;
    tag = "post_rst";
    k = cyc; press_seq(0, k, k + 20);
    tick(20); in_r[0] = 1'b1;
    tick(15);

    if (q.size() != 0) begin
      n_chk++; n_err++;
      $display("FAIL leftover_events count=%0d exp=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
